// File: rtl/queue.sv
// Circular-buffer FIFO with first-word fall-through output.
// Optional feature macro: QUEUE_GUARD_EN
//   undefined : push-only on full overwrites the head entry; pop-only on empty
//               advances the read pointer and wraps count. No error is reported.
//   defined   : those operations are ignored and set the sticky overflow /
//               underflow outputs. Only rst clears these outputs.
module queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full
`ifdef QUEUE_GUARD_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int CAP = 1 << DEPTH;
    localparam logic [DEPTH:0]   CAP_CNT = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0]   CNT_ONE = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] mem [CAP];
    logic [DEPTH-1:0] wr_ptr_reg;
    logic [DEPTH-1:0] rd_ptr_reg;
    logic [DEPTH:0]   count_reg;
    logic [DEPTH:0]   count_next;
    // Low for the first edge after reset release, so that edge ignores push/pop.
    logic             live_reg;
    logic             do_push;
    logic             do_pop;
    logic             adv_rd;

    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CAP_CNT);
    // The head is read asynchronously. Unreset storage is hidden behind the empty check.
    assign data_out = empty ? '0 : mem[rd_ptr_reg];

    // Decide which operations this edge accepts, then compute the next count.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        adv_rd     = 1'b0;
        count_next = count_reg;
`ifdef QUEUE_GUARD_EN
        // A full queue accepts a push only when a pop frees a slot in the same edge.
        do_push = live_reg & push & (~full | pop);
        do_pop  = live_reg & pop & ~empty;
        adv_rd  = do_pop;
`else
        // Pop+push on empty keeps only the push. A pop alone on empty is still taken.
        do_push = live_reg & push;
        do_pop  = live_reg & pop & ~(empty & push);
        // A push alone on full overwrites the head slot, so the head moves forward too.
        adv_rd  = do_pop | (do_push & full & ~pop);
`endif
        if (do_push && !do_pop && !full)
            count_next = count_reg + CNT_ONE;
        else if (do_pop && !do_push)
            count_next = count_reg - CNT_ONE;
    end

    // Pointers, occupancy and the post-reset qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            live_reg   <= 1'b0;
        end else begin
            live_reg  <= 1'b1;
            count_reg <= count_next;
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (adv_rd)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage write port. The array has no reset, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= data_in;
    end

`ifdef QUEUE_GUARD_EN
    // Sticky error flags for rejected operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (live_reg && push && !pop && full)
                overflow <= 1'b1;
            if (live_reg && pop && !push && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue (WIDTH=8, DEPTH=2). A queue-based reference
// model is compared against the DUT on every falling edge. Directed sequences
// with literal expectations pin down the model behaviour.
module tb_queue;

    localparam int W   = 8;
    localparam int D   = 2;
    localparam int CAP = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic [D:0]   count;
    logic         empty;
    logic         full;
`ifdef QUEUE_GUARD_EN
    logic         overflow;
    logic         underflow;
`endif

    queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (data_in),
        .pop      (pop),
        .data_out (data_out),
        .count    (count),
        .empty    (empty),
        .full     (full)
`ifdef QUEUE_GUARD_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en  = 0;
    bit live    = 0;   // model: first edge after reset release is ignored
    bit corrupt = 0;   // model: unguarded underflow makes the contents undefined
    bit m_ovf   = 0;
    bit m_unf   = 0;
    logic [W-1:0] mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply one clock edge worth of push/pop to the queue.
    function automatic void model_update(bit p, bit q, logic [W-1:0] d);
        int n = mq.size();
        if (!live) begin
            live = 1;
            return;
        end
        if (p && q) begin
            if (n == 0) mq.push_back(d);
            else begin
                void'(mq.pop_front());
                mq.push_back(d);
            end
        end else if (p) begin
            if (n < CAP) mq.push_back(d);
            else begin
`ifdef QUEUE_GUARD_EN
                m_ovf = 1;
`else
                void'(mq.pop_front());
                mq.push_back(d);
`endif
            end
        end else if (q) begin
            if (n > 0) void'(mq.pop_front());
            else begin
`ifdef QUEUE_GUARD_EN
                m_unf = 1;
`else
                corrupt = 1;
`endif
            end
        end
    endfunction

    // Compare process: every falling edge, check the DUT against the model.
    always @(negedge clk) begin
        if (chk_en && !corrupt) begin
            chk("count", 32'(count), mq.size());
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == CAP));
            chk("data_out", 32'(data_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`ifdef QUEUE_GUARD_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
`endif
        end
    end

    // Drive one cycle starting at a falling edge. Return at the next falling edge.
    task automatic step(input bit p, input bit q, input logic [W-1:0] d);
        push = p;
        pop = q;
        data_in = d;
        @(posedge clk);
        model_update(p, q, d);
        @(negedge clk);
        push = 0;
        pop = 0;
    endtask

    task automatic psh(input logic [W-1:0] d); step(1, 0, d); endtask
    task automatic popq(); step(0, 1, '0); endtask

    // Assert rst asynchronously mid-cycle, check the immediate effect, then release it.
    task automatic do_reset();
        #3;
        rst = 1;
        mq.delete();
        live = 0;
        corrupt = 0;
        m_ovf = 0;
        m_unf = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        @(negedge clk);
        rst = 0;
        step(1, 1, 8'hFF);
        chk("release_ignored", 32'(count), 0);
    endtask

    initial begin
        bit p, q;
        logic [W-1:0] d;
        rst = 1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("init_count", 32'(count), 0);
        chk("init_empty", 32'(empty), 1);
        chk("init_data_out", 32'(data_out), 0);
        rst = 0;
        step(0, 0, '0);

        // Three pushes. The first value appears at the output after the first edge.
        psh(8'h11);
        chk("fwft_head", 32'(data_out), 32'h11);
        psh(8'h22);
        psh(8'h33);
        chk("three_count", 32'(count), 3);
        chk("three_head", 32'(data_out), 32'h11);
        chk("three_empty", 32'(empty), 0);
        chk("three_full", 32'(full), 0);
        repeat (3) popq();

        // Fill the queue, then drain it completely.
        for (int i = 0; i < 4; i++) psh(8'hA0 + 8'(i));
        chk("fill_full", 32'(full), 1);
        popq(); chk("drain1", 32'(data_out), 32'hA1); chk("drain1_full", 32'(full), 0);
        popq(); chk("drain2", 32'(data_out), 32'hA2);
        popq(); chk("drain3", 32'(data_out), 32'hA3);
        popq(); chk("drain4", 32'(data_out), 0); chk("drain_empty", 32'(empty), 1);

        // Push and pop together on a full queue.
        for (int i = 0; i < 4; i++) psh(8'hA0 + 8'(i));
        step(1, 1, 8'hB4);
        chk("pp_full_count", 32'(count), 4);
        chk("pp_full_head", 32'(data_out), 32'hA1);
        popq(); popq(); popq();
        chk("pp_full_last", 32'(data_out), 32'hB4);
        popq();

        // Push and pop together on an empty queue: only the push is taken.
        step(1, 1, 8'h5A);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_head", 32'(data_out), 32'h5A);
`ifdef QUEUE_GUARD_EN
        chk("pp_empty_unf", 32'(underflow), 0);
`endif
        popq();

        // Push on a full queue, then pop past empty.
        for (int i = 0; i < 4; i++) psh(8'hA0 + 8'(i));
        psh(8'hEE);
`ifdef QUEUE_GUARD_EN
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(data_out), 32'hA0);
        chk("ovf_count", 32'(count), 4);
        for (int i = 0; i < 5; i++) begin
            popq();
            if (i == 2) chk("ovf_no_ee", 32'(data_out), 32'hA3);
        end
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_count", 32'(count), 0);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 0);
        chk("unf_cleared", 32'(underflow), 0);
`else
        chk("ovw_head", 32'(data_out), 32'hA1);
        chk("ovw_count", 32'(count), 4);
        popq(); popq(); popq();
        chk("ovw_tail", 32'(data_out), 32'hEE);
        popq();
        popq();
        chk("unf_wrap_count", 32'(count), 7);
        chk("unf_wrap_empty", 32'(empty), 0);
        do_reset();
`endif

        // Ten pushes with interleaved pops wrap both pointers twice. Then reset while entries remain.
        for (int i = 0; i < 10; i++) step(1, i >= 2, 8'hC0 + 8'(i));
        chk("wrap_head", 32'(data_out), 32'hC8);
        chk("wrap_count", 32'(count), 2);
        do_reset();

        // Random traffic checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            d = 8'($urandom);
`ifndef QUEUE_GUARD_EN
            if (q && !p && mq.size() == 0) q = 0;
`endif
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(p, q, d);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the entry width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the address width; capacity is 2**DEPTH entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 push  input  1  SHALL request an enqueue of data_in at the next rising edge.
REQ-006 data_in  input  WIDTH  SHALL be the data to enqueue, sampled when push is high.
REQ-007 pop  input  1  SHALL request removal of the head entry at the next rising edge.
REQ-008 data_out  output  WIDTH  SHALL show the head (oldest) entry; 0 when empty.
REQ-009 count  output  DEPTH+1  SHALL be the number of stored entries, 0..2**DEPTH.
REQ-010 empty  output  1  SHALL be high exactly when count == 0.
REQ-011 full  output  1  SHALL be high exactly when count == 2**DEPTH.
REQ-012 overflow, underflow  output  1 each  SHALL exist only when QUEUE_GUARD_EN is defined (REQ-030).

Function
REQ-013 Storage SHALL be a circular buffer of 2**DEPTH entries, a DEPTH-bit write pointer and a DEPTH-bit read pointer.
REQ-014 An accepted push SHALL write data_in at the write pointer and advance it by 1, wrapping 2**DEPTH-1 -> 0.
REQ-015 An accepted pop SHALL advance the read pointer by 1 with the same wrap.
REQ-016 count SHALL increment on push-only, decrement on pop-only, and stay unchanged when both are accepted.
REQ-017 Push and pop in the same cycle SHALL both be legal; no assertion restricts them.
REQ-018 data_out SHALL be first-word fall-through: a push into an empty queue at edge N shows data_in on data_out after edge N.
REQ-019 data_out SHALL change only after an edge where a pop is accepted, or a push into an empty queue is accepted.
REQ-020 Push+pop on a full queue SHALL accept both; count stays 2**DEPTH and the new entry lands in the freed slot.
REQ-021 Push+pop on an empty queue SHALL accept the push only; count becomes 1 and data_out equals the pushed data.
REQ-022 Entry order SHALL be strictly first-in first-out across any number of pointer wraps.
REQ-023 Storage SHALL be unreset, writable without read-during-write hazards, and suitable for RAM inference.

Reset
REQ-024 Asserting rst SHALL immediately clear both pointers and count, independent of clk.
REQ-025 During and after reset, data_out SHALL be 0, empty SHALL be 1 and full SHALL be 0.
REQ-026 When present, overflow and underflow SHALL reset to 0.
REQ-027 Reset mid-operation SHALL discard all entries; push and pop in the cycle rst is released SHALL be ignored.
REQ-028 Storage contents SHALL NOT be reset; they stay unobservable because data_out is forced to 0 when empty.

Configuration
REQ-029 Without QUEUE_GUARD_EN, push-only on full SHALL overwrite the head slot and advance both pointers. Pop-only on empty SHALL advance the read pointer and wrap count to 2**(DEPTH+1)-1. No error is reported.
REQ-030 With QUEUE_GUARD_EN, push-only on full and pop-only on empty SHALL be ignored with no state change. Each such event SHALL set the sticky overflow or underflow flag, cleared only by rst.

Verification (WIDTH=8, DEPTH=2, capacity 4)
REQ-031 Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count 3; data_out 0x11 after the first edge; empty 0 and full 0.
REQ-032 Fill with 0xA0..0xA3, then pop 4 times -> data_out 0xA1,0xA2,0xA3,0; full 1 then 0; empty 1 at the end.
REQ-033 Full queue, push 0xB4 with pop -> count stays 4, data_out advances; later pops return 0xB4 last.
REQ-034 Empty queue, push 0x5A with pop -> count 1, data_out 0x5A; with guard, underflow stays 0.
REQ-035 Guard on: push 0xEE when full -> contents unchanged, overflow 1. Pop 5 times from full -> underflow 1 and count 0.
REQ-036 Push 10 values with interleaved pops so pointers wrap twice, then assert rst mid-stream -> FIFO order holds before reset; count 0 and data_out 0 immediately on rst.
